// File: rtl/cnn_bram_pkg.sv
// Shared definitions for the tile-BRAM read path: default geometry, the client
// index type and the read tag that travels alongside each BRAM access.
package cnn_bram_pkg;

    localparam int BRAM_WORD_BITS = 256;
    localparam int BRAM_ADDR_BITS = 12;
    localparam int MAX_REQ        = 8;

    typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rd_tag_t;

    // Round-robin successor of client i among n clients.
    function automatic req_idx_t next_idx(input req_idx_t i, input int n);
        return (int'(i) == n - 1) ? '0 : req_idx_t'(i + 1'b1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first asserted request found
// searching upward from ptr (wrapping) wins.
module rr_arbiter
    import cnn_bram_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output logic [N_REQ-1:0] gnt,
    output req_idx_t         idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[(int'(ptr) + i) % N_REQ]) begin
                any                          = 1'b1;
                gnt[(int'(ptr) + i) % N_REQ] = 1'b1;
                idx                          = req_idx_t'((int'(ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Shares one registered-read BRAM port among N_REQ clients with round-robin
// arbitration, bounded burst locking and a tagged, order-preserving return path.
module bram_rd_arbiter
    import cnn_bram_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_BITS = BRAM_ADDR_BITS,
    parameter int WORD_BITS = BRAM_WORD_BITS,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [N_REQ*ADDR_BITS-1:0] req_addr,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           rvalid,
    output logic [WORD_BITS-1:0]       rdata,
    output logic                       bram_en,
    output logic [ADDR_BITS-1:0]       bram_addr,
    input  logic [WORD_BITS-1:0]       bram_rdata
);

    localparam logic [4:0]       MAX_BURST_W = 5'(MAX_BURST);
    localparam logic [N_REQ-1:0] ONE_HOT0    = {{(N_REQ-1){1'b0}}, 1'b1};

    req_idx_t               ptr_reg, ptr_next;
    logic [3:0]             burst_cnt_reg, burst_cnt_next;
    logic                   burst_reg, burst_next;
    req_idx_t               burst_idx_reg, burst_idx_next;
    logic [ADDR_BITS-1:0]   last_addr_reg;
    rd_tag_t [RD_LAT-1:0]   tag_reg;
    logic [N_REQ-1:0]       rvalid_reg;
    logic [WORD_BITS-1:0]   rdata_reg;

    logic [N_REQ-1:0]       rr_gnt;
    req_idx_t               rr_idx;
    logic                   rr_any;
    logic                   hold;
    logic                   gnt_any;
    req_idx_t               gnt_idx;
    logic [4:0]             cnt_inc;
    logic [ADDR_BITS-1:0]   addr_masked [N_REQ];
    logic [ADDR_BITS-1:0]   addr_sel;
    rd_tag_t                out_tag;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req (req),
        .ptr (ptr_reg),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // A live burst overrides the round-robin choice as long as its owner still requests.
    assign hold = burst_reg && req[burst_idx_reg];

    // Output logic: grant, BRAM enable and address. Grants are suppressed while
    // in reset so no access is issued that the cleared tag pipe could not track.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (rst_n) begin
            if (hold) begin
                gnt     = ONE_HOT0 << burst_idx_reg;
                gnt_idx = burst_idx_reg;
                gnt_any = 1'b1;
            end else begin
                gnt     = rr_gnt;
                gnt_idx = rr_idx;
                gnt_any = rr_any;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr_mask
        assign addr_masked[gi] = gnt[gi] ? req_addr[gi*ADDR_BITS +: ADDR_BITS] : '0;
    end

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            addr_sel = addr_sel | addr_masked[i];
        end
    end

    assign bram_en   = gnt_any;
    assign bram_addr = gnt_any ? addr_sel : last_addr_reg;

    // Next-state logic. The pointer always moves past the granted client, so once a
    // burst exhausts MAX_BURST that client naturally ranks last for one arbitration.
    always_comb begin
        ptr_next       = ptr_reg;
        burst_cnt_next = '0;
        burst_next     = 1'b0;
        burst_idx_next = burst_idx_reg;
        cnt_inc        = hold ? ({1'b0, burst_cnt_reg} + 5'd1) : 5'd1;
        if (gnt_any) begin
            ptr_next       = next_idx(gnt_idx, N_REQ);
            burst_cnt_next = cnt_inc[4] ? 4'hF : cnt_inc[3:0];
            burst_idx_next = gnt_idx;
            burst_next     = lock[gnt_idx] && req[gnt_idx] && (cnt_inc < MAX_BURST_W);
        end
    end

    assign out_tag = tag_reg[RD_LAT-1];

    // State registers, tag pipeline and the registered return path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            burst_cnt_reg <= '0;
            burst_reg     <= 1'b0;
            burst_idx_reg <= '0;
            last_addr_reg <= '0;
            tag_reg       <= '0;
            rvalid_reg    <= '0;
            rdata_reg     <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            burst_reg     <= burst_next;
            burst_idx_reg <= burst_idx_next;
            if (gnt_any) begin
                last_addr_reg <= addr_sel;
            end
            tag_reg[0] <= '{valid: gnt_any, idx: gnt_idx};
            for (int s = 1; s < RD_LAT; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
            rvalid_reg <= out_tag.valid ? (ONE_HOT0 << out_tag.idx) : '0;
            if (out_tag.valid) begin
                rdata_reg <= bram_rdata;
            end
        end
    end

    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Self-checking bench for bram_rd_arbiter: per-scenario grant checks plus a
// scoreboard that matches every rvalid/rdata against the grant that caused it.
module tb_bram_rd_arbiter;

    localparam int N      = 4;
    localparam int AB     = 12;
    localparam int WB     = 256;
    localparam int LAT    = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      lock = '0;
    logic [N*AB-1:0]   req_addr = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [WB-1:0]     rdata;
    logic              bram_en;
    logic [AB-1:0]     bram_addr;
    logic [WB-1:0]     bram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [N-1:0] g;
        logic [AB-1:0] addr;
        int           c;
    } exp_t;
    exp_t sb[$];

    bram_rd_arbiter #(
        .N_REQ     (N),
        .ADDR_BITS (AB),
        .WORD_BITS (WB),
        .RD_LAT    (LAT),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .lock       (lock),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WB-1:0] word_of(input logic [AB-1:0] a);
        logic [WB-1:0] w;
        for (int j = 0; j < 8; j++) begin
            w[j*32 +: 32] = {a, 8'(j), a ^ 12'hC3A};
        end
        return w;
    endfunction

    // BRAM model with one-cycle registered read
    always @(posedge clk) begin
        if (bram_en) bram_rdata <= word_of(bram_addr);
    end

    // Scoreboard: record each grant, match it against the returning strobe
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            checks++;
            if (bram_en !== |gnt) begin
                errors++;
                $display("FAIL bram_en: got %b want %b", bram_en, |gnt);
            end
            if (rvalid !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid: got %b want none", rvalid);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rvalid !== e.g || rdata !== word_of(e.addr) || cyc != e.c + LAT + 1) begin
                        errors++;
                        $display("FAIL rd_return: got rvalid=%b cyc=%0d rdata[31:0]=%h want rvalid=%b cyc=%0d rdata[31:0]=%h",
                                 rvalid, cyc, rdata[31:0], e.g, e.c + LAT + 1, word_of(e.addr) & 256'hFFFF_FFFF);
                    end else begin
                        $display("rd client=%b addr=%h cyc=%0d", rvalid, e.addr, cyc);
                    end
                end
            end
            if (gnt !== '0) sb.push_back('{g: gnt, addr: bram_addr, c: cyc});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic set_addr(input int i, input logic [AB-1:0] a);
        req_addr[i*AB +: AB] = a;
    endtask

    task automatic drain(input int n);
        req  = '0;
        lock = '0;
        repeat (n) next_cycle();
    endtask

    // Check grant this cycle, then advance to the next input slot.
    task automatic expect_gnt(input string name, input logic [N-1:0] want);
        @(negedge clk);
        checks++;
        if (gnt !== want) begin
            errors++;
            $display("FAIL %s: gnt got %b want %b", name, gnt, want);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '1;
        set_addr(0, 12'h5A5);
        @(negedge clk);
        checks++;
        if (gnt !== '0 || bram_en !== 1'b0 || rvalid !== '0 || rdata !== '0 || bram_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b en=%b rvalid=%b rdata0=%h addr=%h want all zero",
                     gnt, bram_en, rvalid, rdata[31:0], bram_addr);
        end
        next_cycle();
        req = '0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bram_addr !== '0 || bram_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: addr=%h en=%b want 000 0", bram_addr, bram_en);
        end
        next_cycle();
    endtask

    task automatic test_single();
        req = 4'b0001;
        set_addr(0, 12'h010);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || bram_addr !== 12'h010) begin
            errors++;
            $display("FAIL single_grant: gnt=%b addr=%h want 0001 010", gnt, bram_addr);
        end
        next_cycle();
        req = '0;
        @(negedge clk);
        checks++;
        if (rvalid !== '0 || bram_addr !== 12'h010) begin
            errors++;
            $display("FAIL single_t1: rvalid=%b held_addr=%h want 0000 010", rvalid, bram_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rvalid !== 4'b0001 || rdata !== word_of(12'h010)) begin
            errors++;
            $display("FAIL single_data: rvalid=%b rdata0=%h want 0001 %h", rvalid, rdata[31:0], word_of(12'h010) & 256'hFFFF_FFFF);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, AB'(12'h100 * i + 3));
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== (4'b0001 << (c % 4)) || bram_addr !== AB'(12'h100 * (c % 4) + 3) || bram_en !== 1'b1) begin
                errors++;
                $display("FAIL rr_%0d: gnt=%b addr=%h en=%b want %b %h 1", c, gnt, bram_addr, bram_en,
                         4'b0001 << (c % 4), AB'(12'h100 * (c % 4) + 3));
            end
            next_cycle();
        end
        drain(4);
    endtask

    task automatic test_burst();
        logic [N-1:0] seq [10];
        seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001,
                4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        do_reset();
        set_addr(0, 12'h0A0);
        set_addr(2, 12'h2C0);
        lock = 4'b0100;
        req  = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            expect_gnt($sformatf("burst_%0d", c), seq[c]);
            req = 4'b0101;
        end
        drain(4);
    endtask

    task automatic test_burst_solo();
        do_reset();
        set_addr(2, 12'h2D0);
        lock = 4'b0100;
        req  = 4'b0100;
        for (int c = 0; c < 6; c++) expect_gnt($sformatf("solo_%0d", c), 4'b0100);
        drain(4);
    endtask

    task automatic test_lock_drop();
        logic [N-1:0] seq [5];
        seq = '{4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        do_reset();
        set_addr(0, 12'h011);
        set_addr(2, 12'h222);
        set_addr(3, 12'h333);
        req  = 4'b0100;
        lock = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            expect_gnt($sformatf("lockdrop_%0d", c), seq[c]);
            req  = 4'b1101;
            lock = 4'b0000;
        end
        drain(4);
    endtask

    task automatic test_withdraw();
        logic [N-1:0] rq [5];
        logic [N-1:0] seq [5];
        rq  = '{4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0000};
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        do_reset();
        set_addr(0, 12'h0F0);
        set_addr(1, 12'h1F1);
        for (int c = 0; c < 9; c++) begin
            req  = (c < 5) ? rq[c] : 4'b0000;
            lock = (c < 4) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            checks++;
            if ((c < 5 && gnt !== seq[c]) || rvalid[1] !== 1'b0) begin
                errors++;
                $display("FAIL withdraw_%0d: gnt=%b rvalid=%b want gnt %b rvalid[1]=0", c, gnt, rvalid,
                         (c < 5) ? seq[c] : 4'b0000);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_addr(0, 12'h400);
        set_addr(1, 12'h411);
        set_addr(3, 12'h433);
        req = 4'b0011;
        expect_gnt("mid_g0", 4'b0001);
        req = 4'b0010;
        expect_gnt("mid_g1", 4'b0010);
        rst_n = 1'b0;
        req   = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== '0 || gnt !== '0) begin
                errors++;
                $display("FAIL mid_rst_%0d: rvalid=%b gnt=%b want 0000 0000", c, rvalid, gnt);
            end
            next_cycle();
        end
        rst_n = 1'b1;
        req   = 4'b1010;
        expect_gnt("mid_ptr0", 4'b0010);
        req = 4'b1000;
        expect_gnt("mid_c3", 4'b1000);
        drain(4);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_burst_solo();
        test_lock_drop();
        test_withdraw();
        test_reset_midflight();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: outstanding=%0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t exceeded budget", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bram_rd_arbiter.md
# bram_rd_arbiter

Shares the single read port of a tile BRAM (256-bit words, 12-bit word address, 1-cycle registered read) between up to `N_REQ` tile-streaming clients, such as column readers feeding the conv engines. Arbitration is round-robin with an optional bounded burst lock, so a client can fetch consecutive columns back-to-back. Read data is broadcast on one registered bus with a one-hot per-client valid strobe. The block sits between the tile readers and the BRAM port.

## Interface
Parameters:
- `N_REQ`, 4: number of requesting clients (2..8).
- `ADDR_BITS`, 12: BRAM word-address width.
- `WORD_BITS`, 256: BRAM word width.
- `RD_LAT`, 1: cycles from address cycle to valid `bram_rdata` (1..3).
- `MAX_BURST`, 4: maximum consecutive grants to one locked client (1..16).

Ports (the block uses one clock, `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  N_REQ  per-client read request
- `lock`  in  N_REQ  per-client burst-lock request, qualified by `req`
- `req_addr`  in  N_REQ*ADDR_BITS  client i address at bits [i*ADDR_BITS +: ADDR_BITS]
- `gnt`  out  N_REQ  one-hot grant, combinational, same cycle as `bram_addr`
- `rvalid`  out  N_REQ  one-hot read-data strobe, 1 cycle
- `rdata`  out  WORD_BITS  registered read data, shared by all clients
- `bram_en`  out  1  BRAM read enable
- `bram_addr`  out  ADDR_BITS  BRAM read address
- `bram_rdata`  in  WORD_BITS  BRAM read data

## Operation
- Each cycle, at most one client is granted from the asserted `req` bits. `gnt` is one-hot or zero. `bram_en` = |`gnt`. `bram_addr` = the granted client's `req_addr`.
- Round-robin pointer `ptr`: search order is ptr, ptr+1, … modulo N_REQ. After a grant to client k with no burst continuation, `ptr` ← (k+1) mod N_REQ. `ptr` does not move when there is no grant.
- Burst:
  - If client k is granted with `lock[k]` and `req[k]` both high, k is granted again next cycle regardless of other requests, up to MAX_BURST consecutive grants.
  - When burst count reaches MAX_BURST, or when `lock[k]` or `req[k]` drops, `ptr` ← k+1 and normal arbitration resumes.
  - If MAX_BURST is reached while `lock[k]` is still high, client k is skipped for exactly one arbitration, provided some other request is pending.
- Burst counter: 4 bits, saturating use; cleared whenever the granted index changes or there is no grant.
- Client protocol:
  - The client holds `req` and `req_addr` stable until it samples `gnt` high at a clock edge, then may present the next address in the following cycle.
  - `req` may be withdrawn before a grant with no side effect.
- Tag pipeline: RD_LAT+1 stages carry {valid, index}. When the tag emerges, `rdata` ← `bram_rdata` and `rvalid[index]` pulses for 1 cycle.
- Fully pipelined: one grant per cycle, no back-pressure on `rvalid`. Clients must accept data when it is strobed.
- When idle, `bram_addr` holds its last value (register `bram_addr` and `bram_en` only if the timing budget requires it; the default is combinational).
- Reset values: `gnt` 0, `bram_en` 0, `rvalid` 0, `rdata` 0, `ptr` 0, burst count 0, all tags invalid. `bram_addr` is 0 while no grant is issued after reset.
- Reset mid-operation clears all in-flight tags. No `rvalid` is issued for reads granted before reset.

## Timing
- Grant in cycle T (`gnt`, `bram_en`, `bram_addr` valid in T).
- `rvalid`/`rdata` valid in cycle T+RD_LAT+1. With RD_LAT=1, grant-to-data is 2 cycles.
- Back-to-back grants in T, T+1 produce `rvalid` in T+2, T+3 in grant order. Ordering is always preserved.
- The `gnt` path is combinational from `req`, `lock`, `ptr` and burst state. No combinational path exists from `bram_rdata` to any output.

## Structure
- Shared package `cnn_bram_pkg`: WORD_BITS and ADDR_BITS defaults, the `req_idx_t` index typedef, and the tag struct {valid, idx}. The package is shared with the tile readers.
- Sub-module `rr_arbiter` (req, ptr → one-hot gnt, idx): pure combinational priority rotate. Burst, pointer and tag logic stay in the top module.

## Test plan
- Single client 0 requests addr 0x010 once → `gnt`=0001 in T, `bram_addr`=0x010, `rvalid`=0001 in T+2 with `rdata` = BRAM word 0x010.
- All four clients request continuously, no lock, from reset → grant order 0,1,2,3,0,…; `rvalid` follows the same order 2 cycles later; `bram_en` is high every cycle.
- Client 2 locks with `req` held and client 0 requesting, MAX_BURST=4 → client 2 granted 4 consecutive cycles, then client 0 for one cycle, then client 2 again.
- Lock dropped after 2 grants → `ptr` advances; the next grant goes to the next requester after client 2.
- Client 1 requests, then withdraws `req` before its turn while client 0 is bursting → client 1 is never granted and no `rvalid[1]` is issued.
- Assert `rst_n` low one cycle after grants to clients 0 and 1 → `rvalid` stays 0 through T+3; after release, a fresh request to client 3 is served with `ptr`=0 ordering.
